// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser
//   Command stage behind the CY68013 slave-FIFO controller. Decodes framed
//   command packets from the EP2 word stream, executes LED write / LED read /
//   echo, and returns a framed response for EP6.
//
//   Command header  : [15:8]=SYNC_BYTE [7:4]=opcode [3:0]=payload length
//   Response header : [15:8]=RESP_SYNC [7:4]=status [3:0]=response length
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   HUNT      | waiting for a command header, drops non-sync words
//   PAYLOAD   | collecting len payload words, idle-timeout armed
//   EXEC      | one cycle: decode opcode, update LEDs, build response
//   RESP_HDR  | presenting the response header
//   RESP_DATA | presenting response payload words
//
// Ports
//   fpga_gclk        system clock (50 MHz)
//   reset            synchronous reset, active-high
//   rx_data/valid    command word stream in, rx_ready back-pressure out
//   tx_data/valid    response word stream out, tx_ready back-pressure in
//   led              LED register
//   err_count        saturating protocol error count
//   busy             high whenever the parser is not hunting for a header
module usb_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  RESP_SYNC      = 8'h5A
) (
  input  logic        fpga_gclk,
  input  logic        reset,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  led,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_PAYLOAD,
    S_EXEC,
    S_RESP_HDR,
    S_RESP_DATA
  } state_t;

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    rlen_q, rlen_d;
  logic          rd_led_q, rd_led_d;
  logic [3:0]    led_q, led_d;
  logic [7:0]    err_q, err_d;
  logic [15:0]   tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic [15:0]   pay_buf_q [16];
  logic          buf_we;

  logic          rx_fire;
  logic          tx_fire;
  logic          err_inc;
  logic [3:0]    status;
  logic [3:0]    rw_idx;
  logic [15:0]   resp_word;

  assign rx_ready  = ~reset & ((state_q == S_HUNT) | (state_q == S_PAYLOAD));
  assign busy      = (state_q != S_HUNT);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign led       = led_q;
  assign err_count = err_q;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid_q & tx_ready;

  // Word to load on the next tx handshake: the first payload word when
  // leaving the header, otherwise the one after the word now on the bus.
  // idx_q is reused as the response word index once the payload is in.
  assign rw_idx    = (state_q == S_RESP_HDR) ? 4'd0 : idx_q + 4'd1;
  assign resp_word = rd_led_q ? {12'h000, led_q} : pay_buf_q[rw_idx];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    rlen_d     = rlen_q;
    rd_led_d   = rd_led_q;
    led_d      = led_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    buf_we     = 1'b0;
    err_inc    = 1'b0;
    status     = 4'd0;

    case (state_q)
      S_HUNT: begin
        if (rx_fire) begin
          if (rx_data[15:8] != SYNC_BYTE) begin
            err_inc = 1'b1;
          end else begin
            op_d     = rx_data[7:4];
            len_d    = rx_data[3:0];
            idx_d    = 4'd0;
            to_cnt_d = '0;
            state_d  = (rx_data[3:0] == 4'd0) ? S_EXEC : S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (rx_fire) begin
          buf_we   = 1'b1;
          idx_d    = idx_q + 4'd1;
          to_cnt_d = '0;
          if (idx_q == len_q - 4'd1) begin
            state_d = S_EXEC;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = S_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_EXEC: begin
        rlen_d   = 4'd0;
        rd_led_d = 1'b0;
        case (op_q)
          4'd1: begin
            if (len_q == 4'd1) begin
              led_d = pay_buf_q[0][3:0];
            end else begin
              status  = 4'd2;
              err_inc = 1'b1;
            end
          end
          4'd2: begin
            if (len_q == 4'd0) begin
              rlen_d   = 4'd1;
              rd_led_d = 1'b1;
            end else begin
              status  = 4'd2;
              err_inc = 1'b1;
            end
          end
          4'd3: begin
            rlen_d = len_q;
          end
          default: begin
            status  = 4'd1;
            err_inc = 1'b1;
          end
        endcase
        tx_data_d  = {RESP_SYNC, status, rlen_d};
        tx_valid_d = 1'b1;
        idx_d      = 4'd0;
        state_d    = S_RESP_HDR;
      end

      S_RESP_HDR: begin
        if (tx_fire) begin
          if (rlen_q == 4'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_HUNT;
          end else begin
            tx_data_d = resp_word;
            idx_d     = 4'd0;
            state_d   = S_RESP_DATA;
          end
        end
      end

      S_RESP_DATA: begin
        if (tx_fire) begin
          if (idx_q == rlen_q - 4'd1) begin
            tx_valid_d = 1'b0;
            state_d    = S_HUNT;
          end else begin
            tx_data_d = resp_word;
            idx_d     = idx_q + 4'd1;
          end
        end
      end

      default: state_d = S_HUNT;
    endcase

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge fpga_gclk) begin
    if (reset) begin
      state_q    <= S_HUNT;
      op_q       <= 4'd0;
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      to_cnt_q   <= '0;
      rlen_q     <= 4'd0;
      rd_led_q   <= 1'b0;
      led_q      <= 4'd0;
      err_q      <= 8'd0;
      tx_data_q  <= 16'h0000;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      rlen_q     <= rlen_d;
      rd_led_q   <= rd_led_d;
      led_q      <= led_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Payload storage needs no reset: entries are only read after being
  // written by the packet that owns them.
  always_ff @(posedge fpga_gclk) begin
    if (buf_we) begin
      pay_buf_q[idx_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
module tb_usb_cmd_parser;

  logic        fpga_gclk = 1'b0;
  logic        reset;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  led;
  logic [7:0]  err_count;
  logic        busy;

  always #5 fpga_gclk = ~fpga_gclk;

  usb_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
    .fpga_gclk (fpga_gclk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .led       (led),
    .err_count (err_count),
    .busy      (busy)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  m_led;
  logic [7:0]  m_err;
  logic [15:0] pl [16];

  bit          mon_stall;
  bit          mon_more;
  bit          mon_last;
  logic [15:0] mon_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bump_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // Reference behaviour of one complete, well-framed command.
  task automatic model_cmd(input logic [15:0] hdr);
    logic [3:0] op  = hdr[7:4];
    logic [3:0] len = hdr[3:0];
    case (op)
      4'd1: begin
        if (len == 4'd1) begin
          m_led = pl[0][3:0];
          exp_q.push_back(16'h5A00);
        end else begin
          exp_q.push_back(16'h5A20);
          bump_err();
        end
      end
      4'd2: begin
        if (len == 4'd0) begin
          exp_q.push_back(16'h5A01);
          exp_q.push_back({12'h000, m_led});
        end else begin
          exp_q.push_back(16'h5A20);
          bump_err();
        end
      end
      4'd3: begin
        exp_q.push_back({8'h5A, 4'h0, len});
        for (int i = 0; i < int'(len); i++) exp_q.push_back(pl[i]);
      end
      default: begin
        exp_q.push_back(16'h5A10);
        bump_err();
      end
    endcase
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    @(negedge fpga_gclk);
    rx_data  = w;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge fpga_gclk);
      n++;
    end
    if (!rx_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL rx_accept_timeout: word %h not accepted within %0d cycles", w, n);
      rx_valid = 1'b0;
      return;
    end
    @(posedge fpga_gclk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge fpga_gclk);
    while ((busy || tx_valid || exp_q.size() != 0) && n < 600) begin
      @(negedge fpga_gclk);
      n++;
    end
    if (n >= 600) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b tx_valid=%0b pending=%0d required all zero",
               busy, tx_valid, exp_q.size());
      exp_q.delete();
    end
    check("err_count", {24'h0, err_count}, {24'h0, m_err});
    check("led", {28'h0, led}, {28'h0, m_led});
  endtask

  task automatic send_cmd(input logic [15:0] hdr, input int gap_max);
    model_cmd(hdr);
    send_word(hdr);
    for (int i = 0; i < int'(hdr[3:0]); i++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge fpga_gclk);
      send_word(pl[i]);
    end
    @(negedge fpga_gclk);
    check("tx_valid_in_exec", {31'h0, tx_valid}, 32'h0);
    @(negedge fpga_gclk);
    check("tx_valid_latency", {31'h0, tx_valid}, 32'h1);
    check("led_after_exec", {28'h0, led}, {28'h0, m_led});
    wait_idle();
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge fpga_gclk);
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    mon_stall = 0;
    mon_more  = 0;
    mon_last  = 0;
    mon_held  = '0;
    forever begin
      @(negedge fpga_gclk);
      #1;
      if (reset) begin
        mon_stall = 0;
        mon_more  = 0;
        mon_last  = 0;
        continue;
      end
      if (mon_stall) begin
        check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_hold_data", {16'h0, tx_data}, {16'h0, mon_held});
      end
      if (mon_more) check("tx_valid_continuous", {31'h0, tx_valid}, 32'h1);
      if (mon_last) check("tx_valid_drop", {31'h0, tx_valid}, 32'h0);
      mon_stall = 0;
      mon_more  = 0;
      mon_last  = 0;
      if (tx_valid) check("rx_ready_during_tx", {31'h0, rx_ready}, 32'h0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_tx: got %h expected no word", tx_data);
        end else begin
          check("tx_word", {16'h0, tx_data}, {16'h0, exp_q.pop_front()});
        end
        if (exp_q.size() != 0) mon_more = 1;
        else                   mon_last = 1;
      end else if (tx_valid) begin
        mon_stall = 1;
        mon_held  = tx_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          opsel;
    logic [3:0]  op;
    logic [3:0]  len;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 16'h0000;
    m_led    = 4'h0;
    m_err    = 8'h00;
    repeat (3) @(posedge fpga_gclk);
    @(negedge fpga_gclk);
    check("reset_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_tx_data", {16'h0, tx_data}, 32'h0);
    check("reset_led", {28'h0, led}, 32'h0);
    check("reset_err", {24'h0, err_count}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;

    // LED write, LED read, stalled echo
    pl[0] = 16'h0009;
    send_cmd(16'hA511, 0);
    send_cmd(16'hA520, 0);
    rdy_mode = 1;
    pl[0] = 16'h1111; pl[1] = 16'h2222; pl[2] = 16'h3333;
    send_cmd(16'hA533, 2);
    rdy_mode = 0;

    // Protocol errors and saturation
    send_word(16'h1234);
    bump_err();
    wait_idle();
    send_cmd(16'hA570, 0);
    for (int i = 0; i < 260; i++) begin
      w = 16'($urandom);
      if (w[15:8] == 8'hA5) w[15:8] = 8'h00;
      send_word(w);
      bump_err();
    end
    wait_idle();

    // Length mismatch on LED write keeps the LEDs
    pl[0] = 16'h0003; pl[1] = 16'h0004;
    send_cmd(16'hA512, 1);

    // Reset in the middle of a payload
    send_word(16'hA532);
    send_word(16'h00AA);
    @(negedge fpga_gclk);
    reset = 1'b1;
    repeat (2) @(negedge fpga_gclk);
    m_led = 4'h0;
    m_err = 8'h00;
    check("midrst_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("midrst_tx_data", {16'h0, tx_data}, 32'h0);
    check("midrst_led", {28'h0, led}, 32'h0);
    check("midrst_err", {24'h0, err_count}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (20) @(posedge fpga_gclk);
    wait_idle();

    // Payload idle timeout
    send_word(16'hA532);
    send_word(16'h00AA);
    repeat (15) @(posedge fpga_gclk);
    @(negedge fpga_gclk);
    check("timeout_busy_before", {31'h0, busy}, 32'h1);
    @(posedge fpga_gclk);
    @(negedge fpga_gclk);
    check("timeout_busy_after", {31'h0, busy}, 32'h0);
    check("timeout_no_tx", {31'h0, tx_valid}, 32'h0);
    bump_err();
    wait_idle();
    send_cmd(16'hA520, 0);

    // Randomized command mix
    for (int it = 0; it < 120; it++) begin
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        w = 16'($urandom);
        if (w[15:8] == 8'hA5) w[15:8] = 8'h3C;
        send_word(w);
        bump_err();
        wait_idle();
      end else begin
        opsel = $urandom_range(0, 3);
        op    = (opsel == 3) ? 4'($urandom_range(0, 15)) : 4'(opsel + 1);
        if ($urandom_range(0, 3) == 0) len = 4'($urandom_range(0, 15));
        else if (op == 4'd1)           len = 4'd1;
        else if (op == 4'd2)           len = 4'd0;
        else                           len = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) pl[i] = 16'($urandom);
        send_cmd({8'hA5, op, len}, 3);
      end
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
